thor2021_int_accept: RTL and testbench

- Sits directly downstream of the Thor2021 priority interrupt controller and upstream of the CPU exception logic.
- Consumes the controller's registered irq level, cause and nmi outputs.
- Decides whether a request beats the current running priority, presents a stable request/cause to the CPU, and completes an ack handshake.
- Keeps a nesting stack of interrupted priority levels, which is restored on return-from-interrupt.

---
 rtl/thor2021_int_pkg.sv | 15 +
 rtl/thor2021_level_stack.sv | 46 ++++
 rtl/thor2021_int_accept.sv | 142 ++++++++++++++
 tb/tb_thor2021_int_accept.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2021_int_pkg.sv
// Shared types and default constants for the Thor2021 interrupt accept path.
package thor2021_int_pkg;

  typedef logic [3:0] level_t;
  typedef logic [7:0] cause_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam cause_t NMI_CAUSE = 8'hFE;
  localparam level_t NMI_LEVEL = 4'hF;

endpackage

// File: rtl/thor2021_level_stack.sv
// LIFO of interrupted priority levels. A push while full is dropped; the top
// reads as zero when the stack is empty.
module thor2021_level_stack
  import thor2021_int_pkg::*;
#(
  parameter int unsigned pDepth = 8
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  logic   pop_i,
  input  level_t data_i,
  output level_t top_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = $clog2(pDepth);

  level_t         mem [pDepth];
  logic   [AW:0]  cnt;
  logic   [AW-1:0] top_idx;

  // pDepth is a power of two, so the count MSB alone marks a full stack
  assign full_o  = cnt[AW];
  assign empty_o = (cnt == '0);
  assign top_idx = cnt[AW-1:0] - 1'b1;
  assign top_o   = empty_o ? '0 : mem[top_idx];

  // Occupancy count; push has priority if both are ever raised together
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (push_i) begin
      if (!full_o) cnt <= cnt + 1'b1;
    end else if (pop_i) begin
      if (!empty_o) cnt <= cnt - 1'b1;
    end
  end

  // Storage write at the current free slot
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[cnt[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/thor2021_int_accept.sv
// Interrupt acceptance stage between the Thor2021 priority controller and the
// CPU: priority/mask check, stable request presentation, ack handshake and a
// nesting stack of interrupted running levels.
module thor2021_int_accept
  import thor2021_int_pkg::*;
#(
  parameter int unsigned pStackDepth = 8,
  parameter cause_t      pNmiCause   = NMI_CAUSE,
  parameter level_t      pNmiLevel   = NMI_LEVEL
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  level_t irq_i,
  input  cause_t cause_i,
  input  logic   nmi_i,
  input  level_t im_i,
  input  logic   int_ack_i,
  input  logic   int_ret_i,
  output logic   int_req_o,
  output level_t int_level_o,
  output cause_t int_cause_o,
  output level_t cur_level_o,
  output logic   ovf_o,
  output logic   err_o
);

  state_e state;
  level_t lat_level;
  cause_t lat_cause;
  logic   is_nmi;
  level_t cur_level;
  logic   nmi_q;
  logic   nmi_pend;
  logic   ovf;
  logic   err;

  logic   irq_elig;
  logic   take_nmi;
  logic   take_irq;
  logic   ack_fire;
  logic   ret_fire;
  logic   stk_full;
  logic   stk_empty;
  level_t stk_top;

  assign ack_fire = int_ack_i && (state == REQ);
  assign ret_fire = int_ret_i && !int_ack_i;
  assign irq_elig = (irq_i != '0) && (irq_i > cur_level) && (irq_i > im_i) && !stk_full;

  // Select what, if anything, gets latched into the request this cycle
  always_comb begin
    take_nmi = 1'b0;
    take_irq = 1'b0;
    if (state == IDLE) begin
      take_nmi = nmi_pend;
      take_irq = !nmi_pend && irq_elig;
    end else if (!int_ack_i) begin
      // an ack freezes the presented values, so upgrades seen with it are dropped
      take_nmi = nmi_pend && !is_nmi;
      take_irq = !(nmi_pend && !is_nmi) && irq_elig && (irq_i > lat_level);
    end
  end

  // Request FSM and latched level/cause/kind
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      lat_level <= '0;
      lat_cause <= '0;
      is_nmi    <= 1'b0;
    end else if (ack_fire) begin
      state <= IDLE;
    end else if (take_nmi) begin
      state     <= REQ;
      lat_level <= pNmiLevel;
      lat_cause <= pNmiCause;
      is_nmi    <= 1'b1;
    end else if (take_irq) begin
      state     <= REQ;
      lat_level <= irq_i;
      lat_cause <= cause_i;
      is_nmi    <= 1'b0;
    end
  end

  // NMI edge detect; a fresh edge wins over the clear from an NMI ack
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_q <= nmi_i;
      if (nmi_i && !nmi_q)        nmi_pend <= 1'b1;
      else if (ack_fire && is_nmi) nmi_pend <= 1'b0;
    end
  end

  // Running priority: raised on ack, restored from the stack on return
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cur_level <= '0;
    end else if (ack_fire) begin
      cur_level <= lat_level;
    end else if (ret_fire) begin
      cur_level <= stk_top;
    end
  end

  // Sticky overflow and protocol error flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (ack_fire && stk_full) ovf <= 1'b1;
      if ((int_ack_i && int_ret_i) || (int_ack_i && (state == IDLE)) ||
          (ret_fire && stk_empty))
        err <= 1'b1;
    end
  end

  thor2021_level_stack #(
    .pDepth (pStackDepth)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ack_fire),
    .pop_i   (ret_fire),
    .data_i  (cur_level),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign int_req_o   = (state == REQ);
  assign int_level_o = lat_level;
  assign int_cause_o = lat_cause;
  assign cur_level_o = cur_level;
  assign ovf_o       = ovf;
  assign err_o       = err;

endmodule

// File: tb/tb_thor2021_int_accept.sv
// Scoreboard bench for thor2021_int_accept: directed scenarios followed by
// random traffic, checked cycle by cycle against a queue-based reference model.
module tb_thor2021_int_accept;

  localparam int unsigned DEPTH     = 8;
  localparam int          NMI_LVL   = 15;
  localparam int          NMI_CAUSE = 8'hFE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq;
  logic [7:0] cause;
  logic       nmi;
  logic [3:0] im;
  logic       ack;
  logic       ret;
  logic       int_req;
  logic [3:0] int_level;
  logic [7:0] int_cause;
  logic [3:0] cur_level;
  logic       ovf;
  logic       err;

  always #5 clk = ~clk;

  thor2021_int_accept #(
    .pStackDepth (DEPTH),
    .pNmiCause   (8'hFE),
    .pNmiLevel   (4'hF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .irq_i       (irq),
    .cause_i     (cause),
    .nmi_i       (nmi),
    .im_i        (im),
    .int_ack_i   (ack),
    .int_ret_i   (ret),
    .int_req_o   (int_req),
    .int_level_o (int_level),
    .int_cause_o (int_cause),
    .cur_level_o (cur_level),
    .ovf_o       (ovf),
    .err_o       (err)
  );

  typedef struct {
    logic       req;
    logic [3:0] lvl;
    logic [7:0] cause;
    logic [3:0] cur;
    logic       ovf;
    logic       err;
    logic       chk_lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: abstract interrupt state plus a queue as the nesting stack
  bit m_req, m_isnmi, m_nmi_pend, m_nmi_q, m_ovf, m_err;
  int m_lvl, m_cause, m_cur;
  int m_stack[$];

  task automatic model_step(output exp_t e);
    bit elig;
    bit nmi_old;
    bit rise;
    if (!rst_n) begin
      m_req = 0; m_isnmi = 0; m_nmi_pend = 0; m_nmi_q = 0; m_ovf = 0; m_err = 0;
      m_lvl = 0; m_cause = 0; m_cur = 0;
      m_stack.delete();
      e.chk_lc = 1'b1;
    end else begin
      elig    = (int'(irq) != 0) && (int'(irq) > m_cur) && (int'(irq) > int'(im)) &&
                (m_stack.size() < DEPTH);
      nmi_old = m_nmi_pend;
      rise    = nmi && !m_nmi_q;
      if (ack && (ret || !m_req)) m_err = 1;
      if (ack && m_req) begin
        if (m_stack.size() == DEPTH) m_ovf = 1;
        else m_stack.push_back(m_cur);
        m_cur = m_lvl;
        m_req = 0;
        if (m_isnmi) m_nmi_pend = 0;
      end else begin
        if (ret && !ack) begin
          if (m_stack.size() == 0) begin
            m_cur = 0;
            m_err = 1;
          end else begin
            m_cur = m_stack.pop_back();
          end
        end
        if (nmi_old && (!m_req || !m_isnmi)) begin
          m_req = 1; m_lvl = NMI_LVL; m_cause = NMI_CAUSE; m_isnmi = 1;
        end else if (elig && (!m_req || int'(irq) > m_lvl)) begin
          m_req = 1; m_lvl = int'(irq); m_cause = int'(cause); m_isnmi = 0;
        end
      end
      if (rise) m_nmi_pend = 1;
      m_nmi_q  = nmi;
      e.chk_lc = m_req;
    end
    e.req   = m_req;
    e.lvl   = 4'(m_lvl);
    e.cause = 8'(m_cause);
    e.cur   = 4'(m_cur);
    e.ovf   = m_ovf;
    e.err   = m_err;
  endtask

  // One clock with the current inputs; expectation is queued once the edge has happened
  task automatic cyc();
    exp_t e;
    model_step(e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; irq = 0; cause = 0; nmi = 0; im = 0; ack = 0; ret = 0;
    cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic pulse_ack();
    ack = 1; cyc(); ack = 0;
  endtask

  task automatic pulse_ret();
    ret = 1; cyc(); ret = 0;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, away from the edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ((int_req !== e.req) || (cur_level !== e.cur) || (ovf !== e.ovf) ||
          (err !== e.err) ||
          (e.chk_lc && ((int_level !== e.lvl) || (int_cause !== e.cause)))) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got req=%0b lvl=%h cause=%h cur=%h ovf=%0b err=%0b, want req=%0b lvl=%h cause=%h cur=%h ovf=%0b err=%0b",
                 $time, int_req, int_level, int_cause, cur_level, ovf, err,
                 e.req, e.lvl, e.cause, e.cur, e.ovf, e.err);
      end
    end
  end

  initial begin
    rst_n = 0; irq = 0; cause = 0; nmi = 0; im = 0; ack = 0; ret = 0;
    @(posedge clk); #1;

    // basic request, ack and re-request guard
    do_reset();
    irq = 4'd3; cause = 8'h21;
    cyc(); cyc();
    pulse_ack();
    repeat (3) cyc();

    // masking by running level and by im
    irq = 4'd2; cause = 8'h12;
    repeat (2) cyc();
    im = 4'd5; irq = 4'd4; cause = 8'h44;
    repeat (2) cyc();
    irq = 4'd6; cause = 8'h66;
    cyc();
    pulse_ack();
    irq = 0; im = 0;
    cyc();

    // upgrade before ack
    do_reset();
    irq = 4'd2; cause = 8'h22;
    cyc();
    irq = 4'd7; cause = 8'h77;
    cyc(); cyc();
    pulse_ack();
    irq = 0;
    cyc();

    // upgrade sampled together with ack is dropped
    do_reset();
    irq = 4'd2; cause = 8'h22;
    cyc();
    irq = 4'd7; cause = 8'h77;
    pulse_ack();
    cyc(); cyc();
    pulse_ack();
    irq = 0;
    cyc();

    // NMI above a running level of 15, held high after ack
    do_reset();
    irq = 4'd15; cause = 8'hF0;
    cyc();
    pulse_ack();
    irq = 0;
    nmi = 1;
    repeat (3) cyc();
    pulse_ack();
    repeat (3) cyc();
    nmi = 0;
    cyc();

    // nesting and underflow
    do_reset();
    irq = 4'd2; cause = 8'h02; cyc(); pulse_ack();
    irq = 4'd5; cause = 8'h05; cyc(); pulse_ack();
    irq = 4'd9; cause = 8'h09; cyc(); pulse_ack();
    irq = 0;
    for (int i = 0; i < 4; i++) begin
      pulse_ret();
      cyc();
    end

    // overflow, blocked irq when full, ack+ret collision
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      irq = 4'(i); cause = 8'(8'h30 + i);
      cyc();
      pulse_ack();
    end
    irq = 4'd9; cause = 8'h39;
    repeat (2) cyc();
    nmi = 1;
    cyc(); cyc();
    pulse_ack();
    nmi = 0; cyc();
    nmi = 1; cyc(); cyc();
    ack = 1; ret = 1; cyc(); ack = 0; ret = 0;
    nmi = 0; irq = 0;
    cyc();

    // ack while idle
    do_reset();
    pulse_ack();
    cyc();

    // reset while requesting
    do_reset();
    irq = 4'd4; cause = 8'h4A;
    cyc();
    rst_n = 0; cyc(); rst_n = 1;
    irq = 0;
    cyc();

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 3) == 0) begin
        irq   = 4'($urandom_range(0, 15));
        cause = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 29) == 0) im = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) nmi = ~nmi;
      ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      ret = ($urandom_range(0, 11) == 0);
      cyc();
    end
    rst_n = 1; ack = 0; ret = 0;
    cyc();

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
